// File: rtl/tage_pkg.sv
// tage_pkg: constants and entry-layout helpers shared by the TAGE lookup and
// update paths.
//
// Entry layout for tagged table t, with TB = tag_bits(t):
//   [2:0]           u   (useful counter, 0..7)
//   [3 +: TB]       tag
//   [3+TB +: 2]     ctr (direction counter, 0..3; ctr[1] is the prediction)
//   bits above 4+TB are unused and always written as 0.
package tage_pkg;

  localparam int NUM_TABLES = 12;
  localparam int ENTRY_W    = 20;
  localparam int IDX_W      = 12;
  localparam int TAG_W      = 15;
  localparam int TAG_LSB    = 3;

  localparam int TAG_BITS [NUM_TABLES] = '{7, 7, 8, 8, 9, 10, 11, 12, 12, 13, 14, 15};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROV  = 2'd1,
    ST_ALLOC = 2'd2,
    ST_DECAY = 2'd3
  } tage_state_e;

  // Tag width of table t (table numbers above 11 fall back to the widest).
  function automatic logic [4:0] tag_bits(input logic [3:0] t);
    logic [4:0] tb;
    tb = 5'd15;
    for (int i = 0; i < NUM_TABLES; i++) begin
      if (t == 4'(i)) tb = 5'(TAG_BITS[i]);
    end
    return tb;
  endfunction

  function automatic logic [4:0] ctr_lsb(input logic [3:0] t);
    return tag_bits(t) + 5'(TAG_LSB);
  endfunction

  // Low TB bits set: the tag bits table t actually stores.
  function automatic logic [TAG_W-1:0] tag_mask(input logic [3:0] t);
    logic [31:0] m;
    m = (32'd1 << tag_bits(t)) - 32'd1;
    return m[TAG_W-1:0];
  endfunction

  // Low 5+TB bits set: every meaningful bit of an entry of table t.
  function automatic logic [ENTRY_W-1:0] field_mask(input logic [3:0] t);
    logic [31:0] m;
    m = (32'd1 << (tag_bits(t) + 5'd5)) - 32'd1;
    return m[ENTRY_W-1:0];
  endfunction

endpackage

// File: rtl/tage_alloc_sel.sv
// tage_alloc_sel: combinational choice of the allocation target and of the
// useful-bit decay set for a mispredicted branch.
//
// Ports:
//   provider_i    table that provided the prediction
//   u_i           u field of every table's looked-up entry
//   lfsr_bit_i    random bit (only with TAGE_ALLOC_RANDOM_EN defined)
//   free_o        some table above the provider has u == 0
//   sel_o         table to allocate into
//   decay_mask_o  tables above the provider with u > 0
//
// Configuration macro: TAGE_ALLOC_RANDOM_EN -- when defined and at least two
// free tables exist, lfsr_bit_i = 1 selects the second-lowest free table.
module tage_alloc_sel
  import tage_pkg::*;
(
  input  logic [3:0]                  provider_i,
  input  logic [NUM_TABLES-1:0][2:0]  u_i,
`ifdef TAGE_ALLOC_RANDOM_EN
  input  logic                        lfsr_bit_i,
`endif
  output logic                        free_o,
  output logic [3:0]                  sel_o,
  output logic [NUM_TABLES-1:0]       decay_mask_o
);

  logic [3:0] first_idx;
  logic       first_found;
`ifdef TAGE_ALLOC_RANDOM_EN
  logic [3:0] second_idx;
  logic       second_found;
`endif

  always_comb begin
    first_idx    = '0;
    first_found  = 1'b0;
`ifdef TAGE_ALLOC_RANDOM_EN
    second_idx   = '0;
    second_found = 1'b0;
`endif
    decay_mask_o = '0;
    for (int j = 0; j < NUM_TABLES; j++) begin
      if (4'(j) > provider_i) begin
        if (u_i[j] == 3'd0) begin
          if (!first_found) begin
            first_idx   = 4'(j);
            first_found = 1'b1;
          end
`ifdef TAGE_ALLOC_RANDOM_EN
          else if (!second_found) begin
            second_idx   = 4'(j);
            second_found = 1'b1;
          end
`endif
        end else begin
          decay_mask_o[j] = 1'b1;
        end
      end
    end
  end

  assign free_o = first_found;

`ifdef TAGE_ALLOC_RANDOM_EN
  assign sel_o = (second_found && lfsr_bit_i) ? second_idx : first_idx;
`else
  assign sel_o = first_idx;
`endif

endmodule

// File: rtl/tage_update.sv
// tage_update: write-side companion of the TAGE lookup path. Takes one
// resolved branch (with its lookup-time snapshot) and issues, one per cycle,
// the table writes on the shared tagged-table write port: the provider
// counter/useful update, then either one allocation into a longer table or a
// decay sweep over the longer tables' useful counters.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   upd_valid/ready transaction handshake (see below)
//   upd_taken       resolved direction
//   upd_provider    provider table 0..11
//   upd_altdir      alternate prediction at lookup
//   upd_index       per-table lookup index
//   upd_tag         per-table computed tag (masked to table width here)
//   upd_entry       per-table entry read at lookup
//   updateData      registered write data
//   updateIndex     registered write address
//   upWren          registered one-hot write enable, zero when idle
//   dbg_state_o     current FSM state (tage_state_e encoding)
//
// Handshake: a transaction transfers on a rising edge where upd_valid and
// upd_ready are both high; upd_ready is high exactly in IDLE, all inputs are
// sampled only at that edge, and upd_valid while not ready is ignored.
//
// Configuration macro: TAGE_ALLOC_RANDOM_EN -- adds a 16-bit LFSR (advanced
// on every accept) that randomises between the two lowest free tables.
module tage_update
  import tage_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                upd_valid,
  output logic                                upd_ready,
  input  logic                                upd_taken,
  input  logic [3:0]                          upd_provider,
  input  logic                                upd_altdir,
  input  logic [NUM_TABLES-1:0][IDX_W-1:0]    upd_index,
  input  logic [NUM_TABLES-1:0][TAG_W-1:0]    upd_tag,
  input  logic [NUM_TABLES-1:0][ENTRY_W-1:0]  upd_entry,
  output logic [ENTRY_W-1:0]                  updateData,
  output logic [IDX_W-1:0]                    updateIndex,
  output logic [NUM_TABLES-1:0]               upWren,
  output logic [1:0]                          dbg_state_o
);

  function automatic logic [NUM_TABLES-1:0] onehot(input logic [3:0] t);
    return {{(NUM_TABLES-1){1'b0}}, 1'b1} << t;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [NUM_TABLES-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int j = NUM_TABLES - 1; j >= 0; j--) begin
      if (m[j]) r = 4'(j);
    end
    return r;
  endfunction

  tage_state_e state_q, state_d;
  tage_state_e prov_next_q, prov_next_d;

  logic [NUM_TABLES-1:0][ENTRY_W-1:0] entry_q;
  logic [NUM_TABLES-1:0][IDX_W-1:0]   index_q;
  logic [NUM_TABLES-1:0]              dec_mask_q, dec_mask_d;
  logic [3:0]                         alloc_tbl_q;
  logic [ENTRY_W-1:0]                 alloc_data_q, alloc_data_d;
  logic [IDX_W-1:0]                   alloc_index_q;

  logic [ENTRY_W-1:0]    data_q, data_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic [NUM_TABLES-1:0] wren_q, wren_d;
  logic                  accept;

  // ---------------------------------------------------------------------
  // Provider update, computed straight from the inputs so the write is on
  // the port the cycle after accept. Out-of-range providers act as 11.
  // ---------------------------------------------------------------------
  logic [3:0]         prov_idx;
  logic [ENTRY_W-1:0] prov_entry, prov_data;
  logic [4:0]         prov_lsb;
  logic [1:0]         prov_ctr, new_ctr;
  logic [2:0]         prov_u, new_u;
  logic               pdir, mispredict;

  always_comb begin
    prov_idx   = (upd_provider > 4'd11) ? 4'd11 : upd_provider;
    prov_entry = upd_entry[prov_idx] & field_mask(prov_idx);
    prov_lsb   = ctr_lsb(prov_idx);
    prov_ctr   = 2'(prov_entry >> prov_lsb);
    prov_u     = prov_entry[2:0];
    pdir       = prov_ctr[1];
    mispredict = (pdir != upd_taken);

    if (upd_taken) new_ctr = (prov_ctr == 2'd3) ? 2'd3 : prov_ctr + 2'd1;
    else           new_ctr = (prov_ctr == 2'd0) ? 2'd0 : prov_ctr - 2'd1;

    // Usefulness only moves when the provider disagreed with the alternate.
    new_u = prov_u;
    if (pdir != upd_altdir) begin
      if (mispredict) new_u = (prov_u == 3'd0) ? 3'd0 : prov_u - 3'd1;
      else            new_u = (prov_u == 3'd7) ? 3'd7 : prov_u + 3'd1;
    end

    prov_data = (prov_entry & ~(ENTRY_W'(3) << prov_lsb) & ~ENTRY_W'(7))
              | (ENTRY_W'(new_ctr) << prov_lsb)
              | ENTRY_W'(new_u);
  end

  // ---------------------------------------------------------------------
  // Allocation / decay selection on the lookup-time u fields.
  // ---------------------------------------------------------------------
  logic [NUM_TABLES-1:0][2:0] in_u;
  logic                       sel_free;
  logic [3:0]                 sel_tbl;
  logic [NUM_TABLES-1:0]      sel_decay;

  always_comb begin
    for (int j = 0; j < NUM_TABLES; j++) in_u[j] = upd_entry[j][2:0];
  end

`ifdef TAGE_ALLOC_RANDOM_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; the bit used is the value at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else if (accept)
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  tage_alloc_sel u_alloc_sel (
    .provider_i   (prov_idx),
    .u_i          (in_u),
`ifdef TAGE_ALLOC_RANDOM_EN
    .lfsr_bit_i   (lfsr_q[0]),
`endif
    .free_o       (sel_free),
    .sel_o        (sel_tbl),
    .decay_mask_o (sel_decay)
  );

  always_comb begin
    alloc_data_d = (ENTRY_W'(upd_tag[sel_tbl] & tag_mask(sel_tbl)) << TAG_LSB)
                 | (ENTRY_W'(upd_taken ? 2'b10 : 2'b01) << ctr_lsb(sel_tbl));
    if (!mispredict || prov_idx == 4'd11) prov_next_d = ST_IDLE;
    else if (sel_free)                    prov_next_d = ST_ALLOC;
    else                                  prov_next_d = ST_DECAY;
  end

  // ---------------------------------------------------------------------
  // Decay write for the lowest table still pending.
  // ---------------------------------------------------------------------
  logic [3:0]         dec_idx;
  logic [ENTRY_W-1:0] dec_entry, dec_data;

  always_comb begin
    dec_idx   = lowest_set(dec_mask_q);
    dec_entry = entry_q[dec_idx] & field_mask(dec_idx);
    dec_data  = {dec_entry[ENTRY_W-1:3], dec_entry[2:0] - 3'd1};
  end

  // ---------------------------------------------------------------------
  // FSM. Each branch computes the write that belongs to the next state so
  // the registered write port lines up with the state it is issued in.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dec_mask_d = dec_mask_q;
    wren_d     = '0;
    data_d     = '0;
    widx_d     = '0;
    accept     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (upd_valid) begin
          accept     = 1'b1;
          state_d    = ST_PROV;
          dec_mask_d = sel_decay;
          wren_d     = onehot(prov_idx);
          data_d     = prov_data;
          widx_d     = upd_index[prov_idx];
        end
      end
      ST_PROV: begin
        if (prov_next_q == ST_ALLOC) begin
          state_d = ST_ALLOC;
          wren_d  = onehot(alloc_tbl_q);
          data_d  = alloc_data_q;
          widx_d  = alloc_index_q;
        end else if (prov_next_q == ST_DECAY) begin
          state_d             = ST_DECAY;
          wren_d              = onehot(dec_idx);
          data_d              = dec_data;
          widx_d              = index_q[dec_idx];
          dec_mask_d[dec_idx] = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALLOC: state_d = ST_IDLE;
      ST_DECAY: begin
        if (dec_mask_q != '0) begin
          wren_d              = onehot(dec_idx);
          data_d              = dec_data;
          widx_d              = index_q[dec_idx];
          dec_mask_d[dec_idx] = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      prov_next_q   <= ST_IDLE;
      entry_q       <= '0;
      index_q       <= '0;
      dec_mask_q    <= '0;
      alloc_tbl_q   <= '0;
      alloc_data_q  <= '0;
      alloc_index_q <= '0;
      wren_q        <= '0;
      data_q        <= '0;
      widx_q        <= '0;
    end else begin
      state_q    <= state_d;
      dec_mask_q <= dec_mask_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      widx_q     <= widx_d;
      if (accept) begin
        prov_next_q   <= prov_next_d;
        entry_q       <= upd_entry;
        index_q       <= upd_index;
        alloc_tbl_q   <= sel_tbl;
        alloc_data_q  <= alloc_data_d;
        alloc_index_q <= upd_index[sel_tbl];
      end
    end
  end

  assign upd_ready   = (state_q == ST_IDLE);
  assign upWren      = wren_q;
  assign updateData  = data_q;
  assign updateIndex = widx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tage_update.sv
module tb_tage_update;

  logic              clk = 1'b0;
  logic              reset;
  logic              upd_valid;
  logic              upd_ready;
  logic              upd_taken;
  logic [3:0]        upd_provider;
  logic              upd_altdir;
  logic [11:0][11:0] upd_index;
  logic [11:0][14:0] upd_tag;
  logic [11:0][19:0] upd_entry;
  logic [19:0]       updateData;
  logic [11:0]       updateIndex;
  logic [11:0]       upWren;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  tage_update dut (
    .clk          (clk),
    .reset        (reset),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_taken    (upd_taken),
    .upd_provider (upd_provider),
    .upd_altdir   (upd_altdir),
    .upd_index    (upd_index),
    .upd_tag      (upd_tag),
    .upd_entry    (upd_entry),
    .updateData   (updateData),
    .updateIndex  (updateIndex),
    .upWren       (upWren),
    .dbg_state_o  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [11:0] wren,
                             input logic [19:0] data, input logic [11:0] idx);
    check({tag, "_wren"},  32'(upWren),      32'(wren));
    check({tag, "_data"},  32'(updateData),  32'(data));
    check({tag, "_index"}, 32'(updateIndex), 32'(idx));
    check({tag, "_ready"}, 32'(upd_ready),   32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wren"},  32'(upWren),    32'd0);
    check({tag, "_ready"}, 32'(upd_ready), 32'd1);
  endtask

  // Driver tasks
  task automatic clear_inputs();
    upd_valid    = 1'b0;
    upd_taken    = 1'b0;
    upd_provider = 4'd0;
    upd_altdir   = 1'b0;
    upd_index    = '0;
    upd_tag      = '0;
    upd_entry    = '0;
  endtask

  // Called just after a falling edge; returns in the cycle after accept.
  task automatic send(input string tag);
    check({tag, "_ready_before"}, 32'(upd_ready), 32'd1);
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic setup_decay();
    clear_inputs();
    upd_provider  = 4'd9;
    upd_taken     = 1'b1;
    upd_altdir    = 1'b0;
    for (int j = 0; j < 9; j++) upd_entry[j] = 20'h00007;
    upd_entry[9]  = 20'h155E0;  // ctr 1, tag 0xABC, u 0
    upd_entry[10] = 20'hE91A2;  // junk bit 19, ctr 3, tag 0x1234, u 2
    upd_entry[11] = 20'h3FFFD;  // ctr 0, tag 0x7FFF, u 5
    upd_index[9]  = 12'h099;
    upd_index[10] = 12'h0AA;
    upd_index[11] = 12'h0BB;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wren",  32'(upWren),      32'd0);
    check("rst_data",  32'(updateData),  32'd0);
    check("rst_index", 32'(updateIndex), 32'd0);
    check("rst_ready", 32'(upd_ready),   32'd1);
    check("rst_state", 32'(dbg_state),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two free tables (5, 7) right after reset: LFSR bit 0 of 16'hACE1 is 1.
    clear_inputs();
    upd_provider = 4'd4;
    upd_taken    = 1'b0;
    upd_altdir   = 1'b1;
    upd_entry[4] = 20'h02000;  // ctr 2, tag 0, u 0
    upd_entry[6] = 20'h00001;
    for (int j = 8; j < 12; j++) upd_entry[j] = 20'h00001;
    upd_tag[5]   = 15'h7FFF;
    upd_tag[7]   = 15'h7FFF;
    upd_index[4] = 12'h104;
    upd_index[5] = 12'h105;
    upd_index[7] = 12'h107;
    send("sel");
    check_write("sel_prov", 12'h010, 20'h01000, 12'h104);
    @(negedge clk);
`ifdef TAGE_ALLOC_RANDOM_EN
    check_write("sel_alloc", 12'h080, 20'h0FFF8, 12'h107);
`else
    check_write("sel_alloc", 12'h020, 20'h03FF8, 12'h105);
`endif
    @(negedge clk);
    check_idle("sel_done");

    // Provider update, correct prediction.
    clear_inputs();
    upd_provider = 4'd3;
    upd_entry[3] = 20'h012D3;
    upd_index[3] = 12'h3A5;
    upd_taken    = 1'b1;
    upd_altdir   = 1'b0;
    send("corr");
    check_write("corr_prov", 12'h008, 20'h01AD4, 12'h3A5);
    @(negedge clk);
    check_idle("corr_done");

    // Allocation into the only free table (4).
    clear_inputs();
    upd_provider = 4'd2;
    upd_taken    = 1'b0;
    upd_altdir   = 1'b0;
    upd_entry[2] = 20'h0188A;  // ctr 3, tag 0x11, u 2
    upd_entry[3] = 20'h00001;
    for (int j = 5; j < 12; j++) upd_entry[j] = 20'h00001;
    upd_tag[4]   = 15'h01AB;
    upd_index[2] = 12'h022;
    upd_index[4] = 12'h044;
    send("alloc");
    check_write("alloc_prov", 12'h004, 20'h01089, 12'h022);
    @(negedge clk);
    check_write("alloc_write", 12'h010, 20'h01D58, 12'h044);
    @(negedge clk);
    check_idle("alloc_done");

    // Decay sweep; valid held high and inputs scrambled while busy.
    setup_decay();
    send("decay");
    upd_valid     = 1'b1;
    upd_provider  = 4'd0;
    upd_entry[10] = 20'h00000;
    check_write("decay_prov", 12'h200, 20'h255E0, 12'h099);
    @(negedge clk);
    check_write("decay_t10", 12'h400, 20'h691A1, 12'h0AA);
    @(negedge clk);
    check_write("decay_t11", 12'h800, 20'h3FFFC, 12'h0BB);
    upd_valid = 1'b0;
    @(negedge clk);
    check_idle("decay_done");
    @(negedge clk);
    check_idle("decay_ignored");

    // Provider 11 mispredicts: single write.
    clear_inputs();
    upd_provider  = 4'd11;
    upd_taken     = 1'b0;
    upd_altdir    = 1'b1;
    upd_entry[11] = 20'h80000;  // ctr 2
    upd_index[11] = 12'h0BB;
    send("p11");
    check_write("p11_prov", 12'h800, 20'h40000, 12'h0BB);
    @(negedge clk);
    check_idle("p11_done");

    // Saturation of ctr at 3 and u at 7; junk upper bits dropped.
    clear_inputs();
    upd_provider = 4'd0;
    upd_taken    = 1'b1;
    upd_altdir   = 1'b0;
    upd_entry[0] = 20'hFFFFF;
    upd_index[0] = 12'h001;
    send("sat");
    check_write("sat_prov", 12'h001, 20'h00FFF, 12'h001);
    @(negedge clk);
    check_idle("sat_done");

    // ctr saturates at 0 on not-taken; u increments.
    clear_inputs();
    upd_provider = 4'd5;
    upd_taken    = 1'b0;
    upd_altdir   = 1'b1;
    upd_entry[5] = 20'h00AA8;  // ctr 0, tag 0x155, u 0
    upd_index[5] = 12'h005;
    send("low");
    check_write("low_prov", 12'h020, 20'h00AA9, 12'h005);
    @(negedge clk);
    check_idle("low_done");

    // Reset in the middle of a decay sweep.
    setup_decay();
    send("rstd");
    check_write("rstd_prov", 12'h200, 20'h255E0, 12'h099);
    @(negedge clk);
    check_write("rstd_t10", 12'h400, 20'h691A1, 12'h0AA);
    reset = 1'b1;
    #1;
    check("rstd_wren",  32'(upWren),     32'd0);
    check("rstd_data",  32'(updateData), 32'd0);
    check("rstd_ready", 32'(upd_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rstd_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tage_update.md
# tage_update

Write-side companion of the TAGE lookup path. It accepts one resolved branch per transaction, carrying the snapshot taken at prediction time: per-table index, computed tag, read entry, provider and alternate direction. It then drives the shared single write port of the twelve tagged tables (`updateData` / `updateIndex` / `upWren`), one table write per cycle. The writes are a provider counter/useful update, then either one allocation into a longer table or a useful-bit decay sweep.

## Interface
- `NUM_TABLES`, 12, number of tagged tables; `upWren` width.
- `ENTRY_W`, 20, entry width on `updateData`.
- `IDX_W`, 12, `updateIndex` width.
- `TAG_W`, 15, width of each `upd_tag` element (masked to table tag bits internally).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `upd_valid` in 1: resolved-branch transaction valid.
- `upd_ready` out 1: high only in IDLE; transfer on `upd_valid & upd_ready`.
- `upd_taken` in 1: resolved outcome.
- `upd_provider` in 4: providing table 0..11.
- `upd_altdir` in 1: alternate prediction at lookup.
- `upd_index` in 12 x [NUM_TABLES]: per-table index used at lookup.
- `upd_tag` in 15 x [NUM_TABLES]: per-table computed tag.
- `upd_entry` in 20 x [NUM_TABLES]: per-table entry read at lookup.
- `updateData` out 20: registered write data.
- `updateIndex` out 12: registered write address.
- `upWren` out 12: registered one-hot write enable, all-zero when idle.

## Operation
- Entry layout for table t with TB = TAG_BITS[t] (7,7,8,8,9,10,11,12,12,13,14,15):
  - u = [2:0], tag = [3 +: TB], ctr = [3+TB +: 2];
  - bits above 4+TB are written as 0.
- Provider direction pdir = ctr[1] of `upd_entry[provider]`; mispredict = (pdir != `upd_taken`).
- FSM states IDLE, PROV, ALLOC, DECAY. Transaction fields and a decay-pending mask are captured on accept.
- IDLE -> PROV on accept.
- PROV writes the provider entry:
  - ctr saturating +1 if taken, -1 if not (range 0..3);
  - if pdir != `upd_altdir`, u saturating +1 when correct, -1 when mispredicted (range 0..7);
  - tag unchanged.
- PROV next state:
  - correct or provider==11 -> IDLE;
  - else a free candidate (j > provider, u of `upd_entry[j]` == 0) exists -> ALLOC;
  - else -> DECAY.
- ALLOC writes table j with tag = `upd_tag[j]` masked to TB, ctr = taken ? 2'b10 : 2'b01, u = 0, index = `upd_index[j]`. Then -> IDLE.
- DECAY writes each table j > provider whose u > 0, ascending, one per cycle, with u-1 and tag/ctr preserved. Leaves -> IDLE after the last write.
- Exactly one `upWren` bit is set in each PROV/ALLOC/DECAY cycle.

## Timing
- Reset values: `upWren` = 0, `updateData` = 0, `updateIndex` = 0, state IDLE, `upd_ready` = 1, LFSR = 16'hACE1.
- Accept at edge N: provider write visible on the outputs in cycle N+1.
- Allocation write in cycle N+2; `upd_ready` high again in cycle N+3.
- Decay: k writes in cycles N+2..N+1+k; `upd_ready` back in cycle N+2+k (k ≤ 11).
- Correct prediction, or provider 11: `upd_ready` back in cycle N+2.
- `upd_valid` while not ready is ignored; inputs are sampled only at accept.
- Reset mid-transaction: `upWren` drops to 0 asynchronously; the pending transaction is discarded.
- Read/write collisions with the lookup port are resolved by the BRAM (old data); this block does not forward.

## Configuration
- `TAGE_ALLOC_RANDOM_EN` defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances on every accept;
  - when at least two free candidates exist and LFSR[0] = 1, the second-lowest free table is allocated, otherwise the lowest.
- Undefined: the lowest free table is always allocated; no LFSR is instantiated.

## Structure
- `tage_pkg`: NUM_TABLES, ENTRY_W, TAG_BITS array, tag-mask constants, and field offset helpers (tag_lsb = 3, ctr_lsb(t) = 3 + TB). Shared with the lookup path.
- Sub-module `tage_alloc_sel`: combinational; inputs provider, u fields and LFSR bit; outputs free flag, chosen table index and decay mask.

## Test plan
- Provider update, correct prediction:
  - stimulus: provider 3, entry 0x12D3 (ctr 2, tag 0x5A, u 3), taken = 1, altdir = 0;
  - response: cycle N+1 `upWren` = 12'h008, `updateIndex` = `upd_index[3]`, `updateData` = 0x1AD4; ready in N+2.
- Allocation, macro off:
  - stimulus: provider 2 mispredicts (taken = 0), u of tables 3..11 nonzero except table 4, `upd_tag[4]` = 0x1AB;
  - response: N+2 `upWren` = 12'h010, `updateData` = 0x1D58.
- Decay:
  - stimulus: provider 9 mispredicts, table 10 u = 2, table 11 u = 5;
  - response: table 10 written with u = 1 at N+2, table 11 with u = 4 at N+3, ready at N+4.
- Provider 11 mispredicts -> one write only, ready at N+2.
- Macro on, tables 5 and 7 free, LFSR[0] = 1 -> `upWren` = 12'h080 at N+2.
- Reset asserted during DECAY -> `upWren` = 0 the same cycle, `upd_ready` = 1, no further writes.
